// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and an elaboration-time log2 helper.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Ceiling log2; clog2(1) is 0 so a single-register bank has no index bits.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  import axi_lite_pkg::*;

  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  resp_t               BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  resp_t               RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi_lite_rd_chan.sv
// Read channel of the register bank: address decode, registered read data and RVALID hold.
module axi_lite_rd_chan
  import axi_lite_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 4,
  parameter int                  ADDR_W   = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic                         enable,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_W-1:0]            rdata,
  output resp_t                        rresp,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_vec,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in
);

  localparam int OFF_W = clog2(DATA_W / 8);

  logic [31:0]         ar_idx;
  logic [NUM_REGS-1:0] ar_hit;
  logic                ar_aligned;
  logic                ar_ok;
  logic                rd_accept;
  logic [DATA_W-1:0]   rd_word;

  assign ar_idx     = 32'(araddr >> OFF_W);
  assign ar_aligned = (araddr[OFF_W-1:0] == '0);
  assign ar_ok      = ar_aligned && (|ar_hit);
  assign rd_accept  = enable && arvalid && !rvalid;
  assign arready    = rd_accept;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    ar_hit  = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ar_hit[i] = (ar_idx == 32'(i));
      if (ar_hit[i]) begin
        rd_word = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : reg_vec[i*DATA_W +: DATA_W];
      end
    end
  end

  // reg_vec is the storage before this edge's write lands, so a same-cycle write is not visible.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (rd_accept) begin
      rvalid <= 1'b1;
      rdata  <= ar_ok ? rd_word : '0;
      rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: byte-strobed RW registers, hardware-sourced RO registers, write strobes.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  axi_lite_if.slave                  bus,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] hw_in,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = clog2(STRB_W);
  localparam int ADDR_W = clog2(NUM_REGS) + OFF_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                init_done;
  logic                bvalid;
  resp_t               bresp;
  logic [31:0]         aw_idx;
  logic [NUM_REGS-1:0] aw_hit;
  logic                aw_aligned;
  logic                aw_ok;
  logic                wr_accept;

  // Both channels are taken together in one cycle; nothing is accepted the first cycle out of reset.
  assign wr_accept   = init_done && bus.AWVALID && bus.WVALID && !bvalid;
  assign bus.AWREADY = wr_accept;
  assign bus.WREADY  = wr_accept;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;

  assign aw_idx     = 32'(bus.AWADDR >> OFF_W);
  assign aw_aligned = (bus.AWADDR[OFF_W-1:0] == '0);
  assign aw_ok      = aw_aligned && (|(aw_hit & ~RO_MASK));

  always_comb begin
    aw_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      aw_hit[i] = (aw_idx == 32'(i));
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_W +: DATA_W] = regs[i];
    end
  end

  // NOTE: the whole bank sits in the reset branch because reset must clear every register; this forces flops, never a RAM macro.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RO_MASK[i]) begin
          regs[i] <= hw_in[i*DATA_W +: DATA_W];
        end else if (wr_accept && aw_ok && aw_hit[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (bus.WSTRB[b]) regs[i][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_done <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
    end else begin
      init_done <= 1'b1;
      wr_pulse  <= '0;
      if (wr_accept) begin
        bvalid   <= 1'b1;
        bresp    <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        wr_pulse <= aw_ok ? aw_hit : '0;
      end else if (bvalid && bus.BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  axi_lite_rd_chan #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .RO_MASK  (RO_MASK)
  ) u_rd_chan (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .enable  (init_done),
    .araddr  (bus.ARADDR),
    .arvalid (bus.ARVALID),
    .arready (bus.ARREADY),
    .rdata   (bus.RDATA),
    .rresp   (bus.RRESP),
    .rvalid  (bus.RVALID),
    .rready  (bus.RREADY),
    .reg_vec (reg_out),
    .hw_in   (hw_in)
  );

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank: a default bank and a 6-register bank with register 3 read-only.
module tb_axi_lite_regbank;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;

  logic [4:0]  awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [5:0]  wr_pulse;

  logic [127:0] reg_out_a;
  logic [3:0]   wr_pulse_a;
  logic [127:0] hw_in_a = '0;
  logic [191:0] reg_out_b;
  logic [5:0]   wr_pulse_b;
  logic [191:0] hw_in_b = '0;

  int n_checks = 0;
  int n_fail = 0;
  rd_exp_t    rd_q[$];
  logic [1:0] wr_q[$];

  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_W(4), .DATA_W(32)) bus_a ();
  axi_lite_if #(.ADDR_W(5), .DATA_W(32)) bus_b ();

  assign bus_a.AWADDR  = awaddr[3:0];
  assign bus_a.AWVALID = awvalid && !sel;
  assign bus_a.WDATA   = wdata;
  assign bus_a.WSTRB   = wstrb;
  assign bus_a.WVALID  = wvalid && !sel;
  assign bus_a.BREADY  = bready;
  assign bus_a.ARADDR  = araddr[3:0];
  assign bus_a.ARVALID = arvalid && !sel;
  assign bus_a.RREADY  = rready;

  assign bus_b.AWADDR  = awaddr;
  assign bus_b.AWVALID = awvalid && sel;
  assign bus_b.WDATA   = wdata;
  assign bus_b.WSTRB   = wstrb;
  assign bus_b.WVALID  = wvalid && sel;
  assign bus_b.BREADY  = bready;
  assign bus_b.ARADDR  = araddr;
  assign bus_b.ARVALID = arvalid && sel;
  assign bus_b.RREADY  = rready;

  assign awready  = sel ? bus_b.AWREADY : bus_a.AWREADY;
  assign wready   = sel ? bus_b.WREADY  : bus_a.WREADY;
  assign bvalid   = sel ? bus_b.BVALID  : bus_a.BVALID;
  assign bresp    = sel ? bus_b.BRESP   : bus_a.BRESP;
  assign arready  = sel ? bus_b.ARREADY : bus_a.ARREADY;
  assign rvalid   = sel ? bus_b.RVALID  : bus_a.RVALID;
  assign rresp    = sel ? bus_b.RRESP   : bus_a.RRESP;
  assign rdata    = sel ? bus_b.RDATA   : bus_a.RDATA;
  assign wr_pulse = sel ? wr_pulse_b    : {2'b00, wr_pulse_a};

  axi_lite_regbank #(
    .DATA_W   (32),
    .NUM_REGS (4),
    .RO_MASK  (4'b0000)
  ) dut_a (
    .ACLK     (clk),
    .ARESETN  (rst_n),
    .bus      (bus_a),
    .reg_out  (reg_out_a),
    .hw_in    (hw_in_a),
    .wr_pulse (wr_pulse_a)
  );

  axi_lite_regbank #(
    .DATA_W   (32),
    .NUM_REGS (6),
    .RO_MASK  (6'b001000)
  ) dut_b (
    .ACLK     (clk),
    .ARESETN  (rst_n),
    .bus      (bus_b),
    .reg_out  (reg_out_b),
    .hw_in    (hw_in_b),
    .wr_pulse (wr_pulse_b)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, output logic [5:0] p1, output logic [5:0] p2);
    int n;
    logic [1:0] e;
    wr_q.push_back(exp_resp);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      tick();
      n++;
    end
    check("wr_handshake_in_time", n < 20, 1'b1);
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    p1 = wr_pulse;
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    e = wr_q.pop_front();
    check("bresp", {bvalid, bresp}, {1'b1, e});
    tick();
    p2 = wr_pulse;
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    rd_exp_t e;
    rd_q.push_back('{exp_data, exp_resp});
    araddr = addr; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    check("rd_handshake_in_time", n < 20, 1'b1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      tick();
      n++;
    end
    e = rd_q.pop_front();
    check("rdata", {rvalid, rdata}, {1'b1, e.data});
    check("rresp", rresp, e.resp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] p1, p2;
    rd_exp_t e;
    logic [1:0] eb;

    hw_in_b[3*32 +: 32] = 32'hDEADBEEF;

    // Reset state with requests already pending.
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (2) tick();
    check("reset_ready", {awready, wready, arready}, 3'b000);
    check("reset_valid", {bvalid, rvalid}, 2'b00);
    check("reset_reg_out", reg_out_a, 128'h0);
    check("reset_wr_pulse", wr_pulse, 6'h0);

    // First cycle after release accepts nothing; the next one would.
    rst_n = 1'b1;
    #1;
    check("post_reset_first_cycle", {awready, wready, arready}, 3'b000);
    tick();
    check("post_reset_second_cycle", {awready, wready, arready}, 3'b111);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();

    // Basic write/read-back of all four registers.
    for (int i = 0; i < 4; i++) begin
      do_write(5'(i * 4), 32'(i + 1), 4'hF, OKAY, p1, p2);
      check("wr_pulse_basic", p1, 6'(1 << i));
    end
    for (int i = 0; i < 4; i++) do_read(5'(i * 4), 32'(i + 1), OKAY);

    // Byte strobes.
    do_write(5'h0, 32'h11223344, 4'hF, OKAY, p1, p2);
    do_write(5'h0, 32'hAABBCCDD, 4'b0101, OKAY, p1, p2);
    check("wr_pulse_strb_first", p1, 6'b000001);
    check("wr_pulse_strb_second", p2, 6'b000000);
    check("reg_out_strb", reg_out_a[31:0], 32'h11BB33DD);
    do_read(5'h0, 32'h11BB33DD, OKAY);

    // Same-cycle read and write of register 1, then a stalled write response.
    do_write(5'h4, 32'd5, 4'hF, OKAY, p1, p2);
    bready = 1'b0;
    awaddr = 5'h4; wdata = 32'd9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h4; arvalid = 1'b1;
    rd_q.push_back('{32'd5, OKAY});
    wr_q.push_back(OKAY);
    #1;
    check("same_cycle_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    awaddr = 5'h8; wdata = 32'h77; wstrb = 4'hF;
    e = rd_q.pop_front();
    check("same_cycle_rdata", {rvalid, rdata}, {1'b1, e.data});
    check("same_cycle_rresp", rresp, e.resp);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bvalid_held", {bvalid, bresp}, {1'b1, OKAY});
      check("awready_blocked", {awready, wready}, 2'b00);
      @(posedge clk);
      #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    eb = wr_q.pop_front();
    check("stalled_bresp", {bvalid, bresp}, {1'b1, eb});
    bready = 1'b1;
    tick();
    check("bvalid_released", bvalid, 1'b0);
    do_read(5'h4, 32'd9, OKAY);
    do_read(5'h8, 32'd3, OKAY);

    // Reset with both responses outstanding.
    bready = 1'b0; rready = 1'b0;
    awaddr = 5'h0; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h0; arvalid = 1'b1;
    #1;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("pre_reset_pending", {bvalid, rvalid}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {bvalid, rvalid}, 2'b00);
    check("async_reset_regs", reg_out_a, 128'h0);
    check("async_reset_data", {rdata, rresp, bresp}, 36'h0);
    tick();
    rst_n = 1'b1;
    bready = 1'b1; rready = 1'b1;
    repeat (2) tick();

    // Six-register bank: RO register 3 and address errors.
    sel = 1'b1;
    #1;
    do_write(5'hC, 32'h12345678, 4'hF, SLVERR, p1, p2);
    check("ro_write_no_pulse", {p1, p2}, 12'h0);
    do_read(5'hC, 32'hDEADBEEF, OKAY);
    check("ro_reg_out", reg_out_b[3*32 +: 32], 32'hDEADBEEF);
    do_read(5'h18, 32'h0, SLVERR);
    do_write(5'h18, 32'hFFFFFFFF, 4'hF, SLVERR, p1, p2);
    check("oor_write_no_pulse", p1, 6'h0);
    do_write(5'h2, 32'hFFFFFFFF, 4'hF, SLVERR, p1, p2);
    check("misaligned_write_no_pulse", p1, 6'h0);
    do_read(5'h0, 32'h0, OKAY);
    do_read(5'h2, 32'h0, SLVERR);
    do_write(5'h14, 32'hCAFEF00D, 4'hF, OKAY, p1, p2);
    check("last_reg_pulse", p1, 6'b100000);
    do_read(5'h14, 32'hCAFEF00D, OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
